bin_to_7seg: RTL and testbench

Registered 4-bit code to 7-segment pattern decoder for the multiplexed display scanner. The scanner instantiates one per digit position. Each instance converts a digit code (0-9, blank, dash) plus a decimal-point request into an 8-bit segment pattern. The pattern is held in a register and presented to the digit driver one `clk` after the code is loaded.

---
 rtl/bin_to_7seg.sv | 104 ++++++++++
 tb/tb_bin_to_7seg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bin_to_7seg.sv
// bin_to_7seg: registered 4-bit digit code to 7-segment pattern decoder.
// One instance per digit position of the display scanner. The output pattern
// {a,b,c,d,e,f,g,dp} is registered and appears one clk after a load (en=1).
// Codes 0-9 are digits, 10 is blank, 11 is a dash, 12-15 are invalid
// (all segments off, dp off, code_err set).
// Priority: reset > lamp_test > blank > code decode.
// Optional build macro: BIN_TO_7SEG_SEG_ACTIVE_LOW_EN -- when defined, seg is
// the bitwise inverse of the active-high pattern (common-anode boards);
// code_err is not affected.

module bin_to_7seg (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [3:0] bin,
   input  logic       dp_in,
   input  logic       blank,
   input  logic       lamp_test,
   output logic [7:0] seg,
   output logic       code_err
);

`ifdef BIN_TO_7SEG_SEG_ACTIVE_LOW_EN
   // Common-anode board: every segment bit is inverted on the way out.
   localparam logic [7:0] POL_MASK = 8'hFF;
`else
   // Common-cathode board: segment bits are used as decoded.
   localparam logic [7:0] POL_MASK = 8'h00;
`endif

   // Physical patterns for the override cases, already in board polarity.
   localparam logic [7:0] SEG_ALL_OFF = 8'h00 ^ POL_MASK;
   localparam logic [7:0] SEG_ALL_ON  = 8'hFF ^ POL_MASK;

   // Active-high {a,b,c,d,e,f,g} pattern for a digit code; dp is added later.
   function automatic logic [6:0] decode_segments(input logic [3:0] code);
      logic [6:0] pattern;
      case (code)
         4'd0:    pattern = 7'b111_1110;  // 0xFC without dp
         4'd1:    pattern = 7'b011_0000;  // 0x60
         4'd2:    pattern = 7'b110_1101;  // 0xDA
         4'd3:    pattern = 7'b111_1001;  // 0xF2
         4'd4:    pattern = 7'b011_0011;  // 0x66
         4'd5:    pattern = 7'b101_1011;  // 0xB6
         4'd6:    pattern = 7'b101_1111;  // 0xBE
         4'd7:    pattern = 7'b111_0000;  // 0xE0
         4'd8:    pattern = 7'b111_1111;  // 0xFE
         4'd9:    pattern = 7'b111_1011;  // 0xF6
         4'd10:   pattern = 7'b000_0000;  // blank code
         4'd11:   pattern = 7'b000_0001;  // dash: segment g only
         default: pattern = 7'b000_0000;  // invalid codes 12-15
      endcase
      return pattern;
   endfunction

   logic [7:0] seg_q;
   logic [7:0] seg_d;
   logic       code_err_q;
   logic       code_err_d;
   logic       code_invalid;

   // Codes 12-15 are exactly those with the two top bits set.
   assign code_invalid = bin[3] & bin[2];

   // Next-state selection: hold unless loading, then apply the override priority.
   always_comb begin
      seg_d      = seg_q;
      code_err_d = code_err_q;
      if (en) begin
         if (lamp_test) begin
            seg_d      = SEG_ALL_ON;
            code_err_d = 1'b0;
         end else if (blank) begin
            seg_d      = SEG_ALL_OFF;
            code_err_d = 1'b0;
         end else if (code_invalid) begin
            // dp is suppressed so a bad code never shows a stray point.
            seg_d      = SEG_ALL_OFF;
            code_err_d = 1'b1;
         end else begin
            seg_d      = {decode_segments(bin), dp_in} ^ POL_MASK;
            code_err_d = 1'b0;
         end
      end else begin
         seg_d      = seg_q;
         code_err_d = code_err_q;
      end
   end

   // Output registers; asynchronous reset blanks the digit immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg_q      <= SEG_ALL_OFF;
         code_err_q <= 1'b0;
      end else begin
         seg_q      <= seg_d;
         code_err_q <= code_err_d;
      end
   end

   assign seg      = seg_q;
   assign code_err = code_err_q;

endmodule

// File: tb/tb_bin_to_7seg.sv
// Directed self-checking bench for bin_to_7seg.
// Expected patterns are written in active-high form and converted to board
// polarity by pol() so the same bench serves both builds of the decoder.

module tb_bin_to_7seg;

   logic       clk;
   logic       reset;
   logic       en;
   logic [3:0] bin;
   logic       dp_in;
   logic       blank;
   logic       lamp_test;
   logic [7:0] seg;
   logic       code_err;

   int n_pass;
   int n_total;

   logic [7:0] sweep_tbl [0:11];

   bin_to_7seg dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .bin       (bin),
      .dp_in     (dp_in),
      .blank     (blank),
      .lamp_test (lamp_test),
      .seg       (seg),
      .code_err  (code_err)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Active-high expected pattern to the polarity of the build under test.
   function automatic logic [7:0] pol(input logic [7:0] active_high);
`ifdef BIN_TO_7SEG_SEG_ACTIVE_LOW_EN
      return ~active_high;
`else
      return active_high;
`endif
   endfunction

   // Advance past the next rising edge; inputs change and outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_seg(input string tag, input logic [7:0] expected_ah);
      logic [7:0] expected;
      expected = pol(expected_ah);
      n_total++;
      assert (seg === expected) n_pass++;
      else $error("FAIL %s: seg observed 0x%02h expected 0x%02h", tag, seg, expected);
   endtask

   task automatic check_err(input string tag, input logic expected);
      n_total++;
      assert (code_err === expected) n_pass++;
      else $error("FAIL %s: code_err observed %0b expected %0b", tag, code_err, expected);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      sweep_tbl[0]  = 8'hFC; sweep_tbl[1]  = 8'h60; sweep_tbl[2]  = 8'hDA;
      sweep_tbl[3]  = 8'hF2; sweep_tbl[4]  = 8'h66; sweep_tbl[5]  = 8'hB6;
      sweep_tbl[6]  = 8'hBE; sweep_tbl[7]  = 8'hE0; sweep_tbl[8]  = 8'hFE;
      sweep_tbl[9]  = 8'hF6; sweep_tbl[10] = 8'h00; sweep_tbl[11] = 8'h02;

      // Reset held low with a load pending: output stays off across edges.
      reset = 1'b0; en = 1'b1; bin = 4'd8; dp_in = 1'b0;
      blank = 1'b0; lamp_test = 1'b0;
      #2;
      check_seg("reset_initial", 8'h00);
      check_err("reset_initial_err", 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_seg("reset_held", 8'h00);
         check_err("reset_held_err", 1'b0);
      end

      // Release reset; first edge with en=1 loads the 8.
      reset = 1'b1;
      tick();
      check_seg("first_load_8", 8'hFE);
      check_err("first_load_8_err", 1'b0);

      // Sweep all valid codes back to back, one new pattern per cycle.
      for (int c = 0; c < 12; c++) begin
         bin = 4'(c);
         tick();
         check_seg($sformatf("sweep_%0d", c), sweep_tbl[c]);
         check_err($sformatf("sweep_%0d_err", c), 1'b0);
      end

      // Dash with dp requested keeps the dp bit.
      bin = 4'd11; dp_in = 1'b1;
      tick();
      check_seg("dash_dp", 8'h03);

      // Invalid code: everything off including dp, error flagged.
      bin = 4'd13; dp_in = 1'b1;
      tick();
      check_seg("invalid_13", 8'h00);
      check_err("invalid_13_err", 1'b1);
      bin = 4'd3; dp_in = 1'b0;
      tick();
      check_seg("after_invalid_3", 8'hF2);
      check_err("after_invalid_3_err", 1'b0);
      bin = 4'd12; dp_in = 1'b1;
      tick();
      check_seg("invalid_12", 8'h00);
      check_err("invalid_12_err", 1'b1);
      bin = 4'd15; dp_in = 1'b0;
      tick();
      check_seg("invalid_15", 8'h00);
      check_err("invalid_15_err", 1'b1);

      // Decimal point, then hold while en=0 even as inputs change.
      bin = 4'd5; dp_in = 1'b1;
      tick();
      check_seg("five_dp", 8'hB7);
      check_err("five_dp_err", 1'b0);
      en = 1'b0; bin = 4'd1; dp_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_seg("hold_en0", 8'hB7);
      end
      lamp_test = 1'b1; blank = 1'b1; bin = 4'd14;
      tick();
      check_seg("hold_ignores_overrides", 8'hB7);
      check_err("hold_ignores_overrides_err", 1'b0);

      // Error flag also holds while en=0.
      en = 1'b1; lamp_test = 1'b0; blank = 1'b0; bin = 4'd14;
      tick();
      check_err("load_14_err", 1'b1);
      en = 1'b0; bin = 4'd2;
      tick();
      tick();
      check_err("hold_err_en0", 1'b1);
      check_seg("hold_err_seg", 8'h00);

      // Overrides: lamp_test beats blank, blank beats code; both clear code_err.
      en = 1'b1; bin = 4'd7; dp_in = 1'b0; lamp_test = 1'b1; blank = 1'b1;
      tick();
      check_seg("lamp_and_blank", 8'hFF);
      check_err("lamp_and_blank_err", 1'b0);
      lamp_test = 1'b0;
      tick();
      check_seg("blank_only", 8'h00);
      check_err("blank_only_err", 1'b0);
      blank = 1'b0;
      tick();
      check_seg("override_release_7", 8'hE0);
      bin = 4'd13; lamp_test = 1'b1;
      tick();
      check_seg("lamp_on_invalid", 8'hFF);
      check_err("lamp_on_invalid_err", 1'b0);
      lamp_test = 1'b0; blank = 1'b1; dp_in = 1'b1;
      tick();
      check_seg("blank_on_invalid", 8'h00);
      check_err("blank_on_invalid_err", 1'b0);
      blank = 1'b0; dp_in = 1'b0;

      // Asynchronous reset between edges clears output before the next edge.
      bin = 4'd9;
      tick();
      check_seg("pre_async_9", 8'hF6);
      bin = 4'd14;
      tick();
      check_err("pre_async_err", 1'b1);
      bin = 4'd9;
      tick();
      #2;
      reset = 1'b0;
      #1;
      check_seg("async_reset_mid", 8'h00);
      check_err("async_reset_mid_err", 1'b0);
      tick();
      check_seg("async_reset_edge", 8'h00);
      #2;
      reset = 1'b1;
      bin = 4'd4; dp_in = 1'b1;
      tick();
      check_seg("post_reset_4dp", 8'h67);
      check_err("post_reset_4dp_err", 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
